md_iter_unit: RTL and testbench
===============================

Name: md_iter_unit

Overview:
- Parametrised iterative multiply/divide engine that produces the HI/LO pair for MULT/MULTU/DIV/DIVU.
- Sits in the execute stage. The decoder's mdToHilo, mulOrdiv and mdIsSign controls drive start, op_mul and md_is_sign.
- Replaces the single-cycle multiply/divide path with a start/busy/done handshake plus a pipeline stall.
- Adds flush cancel, divide-by-zero handling and optional early-out for multiply by zero.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- EARLY_ZERO, 1, when 1 a multiply with either operand zero skips iteration.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op_mul  in  1  1 = multiply, 0 = divide; sampled with start.
- md_is_sign  in  1  1 = signed operands; sampled with start.
- a  in  WIDTH  multiplicand / dividend (rs).
- b  in  WIDTH  multiplier / divisor (rt).
- cancel  in  1  pipeline flush; aborts any operation in flight.
- busy  out  1  operation in progress (PREP, CALC, FIX).
- done  out  1  one-cycle pulse; hi/lo are valid from this cycle.
- hi  out  WIDTH  product high half / remainder.
- lo  out  WIDTH  product low half / quotient.
- stall  out  1  combinational: busy | (start & ~cancel & (state==IDLE | state==DONE)).

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers 0. Deasserting reset mid-operation leaves the unit in IDLE with no done pulse.
- States: IDLE, PREP, CALC, FIX, DONE.
- Accept: start=1 & cancel=0 in IDLE or DONE → PREP on the next edge; operands, op_mul and md_is_sign are latched at that edge. start in PREP/CALC/FIX is ignored.
- PREP (1 cycle): take absolute values when md_is_sign=1, otherwise pass operands unchanged; record sign_a and sign_b; load iteration counter = WIDTH.
  - Divide with b==0 → FIX.
  - Multiply with EARLY_ZERO=1 and a==0 or b==0 → FIX with product 0.
  - Otherwise → CALC.
- CALC (exactly WIDTH cycles):
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract giving an unsigned quotient and remainder.
  - Counter decrements each cycle; when it reaches 0 → FIX.
- FIX (1 cycle), signed correction, then → DONE:
  - Product is negated when sign_a ^ sign_b.
  - Quotient is negated when sign_a ^ sign_b.
  - Remainder takes sign_a.
  - hi/lo are registered at the FIX→DONE edge.
- Divide by zero: hi=a (as latched), lo=all ones, no sign correction.
- Overflow case: signed divide of -2^(WIDTH-1) by -1 gives lo=0x80000000 and hi=0 (wraps, no trap).
- DONE (1 cycle): done=1, busy=0. Next state: PREP if start accepted this cycle, otherwise IDLE.
- hi/lo hold their value until the next FIX→DONE edge. Cancel never corrupts them.
- Latency (normal path): busy rises the cycle after accept; done is high exactly WIDTH+2 cycles after busy first rises (34 for WIDTH=32). Early-out and divide-by-zero paths: done 2 cycles after busy rises.
- cancel=1 in PREP/CALC/FIX/DONE → IDLE next edge: no done pulse, hi/lo unchanged. cancel with start in the same cycle: cancel wins, start is ignored.
- Arithmetic is purely combinational per iteration. No division by zero may reach the datapath.

Test Plan:
- Signed multiply, WIDTH=32: a=0xFFFFFFFD (-3), b=5, signed → hi=0xFFFFFFFF, lo=0xFFFFFFF1; done 34 cycles after busy rises; stall high from the start cycle until the cycle before done.
- Unsigned divide: a=0xFFFFFFFF, b=0x10 → lo=0x0FFFFFFF, hi=0xF.
- Signed divide: a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Overflow divide: a=0x80000000, b=0xFFFFFFFF, signed → lo=0x80000000, hi=0.
- Divide by zero: a=0x1234, b=0, divide → hi=0x1234, lo=0xFFFFFFFF, done 2 cycles after busy.
- Early zero: a=0, b=0x55, multiply, EARLY_ZERO=1 → hi=lo=0, done 2 cycles after busy.
- Cancel: assert cancel at CALC cycle 10 → busy drops next cycle, no done, hi/lo keep the previous result.
- Back-to-back: start during DONE is accepted and PREP follows immediately.
- Reset: pull resetn low mid-CALC → busy/done/hi/lo=0 asynchronously; after release the unit is in IDLE.

Source files
------------

// File: rtl/md_iter_unit.sv
// Iterative multiply/divide engine producing HI/LO for MULT/MULTU/DIV/DIVU.
// Radix-2 shift-add multiply and restoring divide, with a start/busy/done handshake and flush cancel.
module md_iter_unit #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             op_mul,
    input  logic             md_is_sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state, state_nxt;
    logic               op_mul_q, is_sign_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               sign_a, sign_b, div_zero;
    logic [CW-1:0]      cnt;
    // acc upper half: partial product / remainder; lower half: multiplier / quotient
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;

    logic               accept, short_path, mul_zero;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign accept = start & ~cancel & (state == S_IDLE | state == S_DONE);
    assign busy   = (state == S_PREP) | (state == S_CALC) | (state == S_FIX);
    assign done   = (state == S_DONE);
    assign stall  = busy | accept;

    assign abs_a = (is_sign_q & a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b = (is_sign_q & b_q[WIDTH-1]) ? -b_q : b_q;

    assign mul_zero   = EARLY_ZERO && (a_q == '0 || b_q == '0);
    assign short_path = op_mul_q ? mul_zero : (b_q == '0);

    // One multiply step: conditionally add the multiplicand, then shift the pair right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // One restoring divide step: shift in the next dividend bit, subtract if it fits.
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_sub   = div_shift[WIDTH-1:0] - opnd;
    assign div_next  = div_ge ? {div_sub, acc[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (div_zero) begin
            fix_hi = a_q;
            fix_lo = '1;
        end else if (op_mul_q) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else begin
            fix_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_PREP;
            S_PREP: begin
                if (cancel)          state_nxt = S_IDLE;
                else if (short_path) state_nxt = S_FIX;
                else                 state_nxt = S_CALC;
            end
            S_CALC: begin
                if (cancel)                 state_nxt = S_IDLE;
                else if (cnt == CW'(1))     state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = cancel ? S_IDLE : S_DONE;
            S_DONE: state_nxt = accept ? S_PREP : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            op_mul_q  <= 1'b0;
            is_sign_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div_zero  <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q       <= a;
                b_q       <= b;
                op_mul_q  <= op_mul;
                is_sign_q <= md_is_sign;
            end
            case (state)
                S_PREP: begin
                    sign_a   <= is_sign_q & a_q[WIDTH-1];
                    sign_b   <= is_sign_q & b_q[WIDTH-1];
                    div_zero <= ~op_mul_q & (b_q == '0);
                    cnt      <= CNT_INIT;
                    opnd     <= op_mul_q ? abs_a : abs_b;
                    if (op_mul_q)
                        acc <= mul_zero ? '0 : {{WIDTH{1'b0}}, abs_b};
                    else
                        acc <= {{WIDTH{1'b0}}, abs_a};
                end
                S_CALC: begin
                    cnt <= cnt - 1'b1;
                    acc <= op_mul_q ? mul_next : div_next;
                end
                S_FIX: begin
                    if (!cancel) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_iter_unit.sv
// Self-checking bench for md_iter_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written cancel / back-to-back / reset sequences.
module tb_md_iter_unit;

    logic        clk, resetn, start, op_mul, md_is_sign, cancel;
    logic [31:0] a_in, b_in;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    md_iter_unit #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op_mul(op_mul),
        .md_is_sign(md_is_sign), .a(a_in), .b(b_in), .cancel(cancel),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV integer division truncates toward zero.
    function automatic void model(input logic m, input logic s, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] h,
                                  output logic [31:0] l, output int lat);
        longint sa, sb, p, q, r;
        sa = s ? longint'($signed(a)) : longint'({32'h0, a});
        sb = s ? longint'($signed(b)) : longint'({32'h0, b});
        if (m) begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
            lat = (a == 0 || b == 0) ? 2 : 34;
        end else if (b == 0) begin
            h = a;
            l = 32'hFFFF_FFFF;
            lat = 2;
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
            lat = 34;
        end
    endfunction

    // Called at a falling edge; applies a request and checks the combinational stall.
    task automatic issue(input logic m, input logic s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op_mul = m;
        md_is_sign = s;
        a_in = a;
        b_in = b;
        #1;
        check("stall_on_start", stall, 1'b1);
    endtask

    // Follows an issued request to its done pulse; returns at the falling edge where done is high.
    task automatic finish_op(input string name, input logic [31:0] eh, input logic [31:0] el,
                             input int elat);
        int k = 0;
        bit stall_ok = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, " busy_rise"}, busy, 1'b1);
        for (int i = 1; i <= 100; i++) begin
            if (!stall || !busy) stall_ok = 1'b0;
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
        end
        check({name, " latency"}, k, elat);
        check({name, " stall_while_busy"}, stall_ok, 1'b1);
        check({name, " stall_at_done"}, stall, 1'b0);
        check({name, " busy_at_done"}, busy, 1'b0);
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        issue(v.m, v.s, v.a, v.b);
        finish_op(name, v.exp_hi, v.exp_lo, v.lat);
        @(negedge clk);
        check({name, " done_pulse"}, done, 1'b0);
    endtask

    vec_t vecs[11];
    vec_t rv;

    initial begin
        bit seen_done;
        resetn = 1'b0;
        start = 1'b0;
        op_mul = 1'b0;
        md_is_sign = 1'b0;
        a_in = '0;
        b_in = '0;
        cancel = 1'b0;

        vecs[0]  = '{1'b1, 1'b1, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 34};
        vecs[1]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 34};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
        vecs[3]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 34};
        vecs[4]  = '{1'b0, 1'b0, 32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF, 2};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,         32'h55,        32'h0,         32'h0,         2};
        vecs[6]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
        vecs[7]  = '{1'b0, 1'b1, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 34};
        vecs[8]  = '{1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         34};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 2};
        vecs[10] = '{1'b1, 1'b1, 32'h7,         32'h0,         32'h0,         32'h0,         2};

        #12;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("idle stall", stall, 1'b0);

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Cancel mid-CALC: the previous result must survive.
        run_vec("pre_cancel", '{1'b1, 1'b0, 32'h0001_0000, 32'h0003_0000, 32'h3, 32'h0, 34});
        issue(1'b0, 1'b0, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel busy_drop", busy, 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("cancel no_done", seen_done, 1'b0);
        check("cancel hi_kept", hi, 32'h3);
        check("cancel lo_kept", lo, 32'h0);

        // Cancel together with start in DONE: cancel wins.
        issue(1'b1, 1'b0, 32'd6, 32'd7);
        finish_op("cxl_done", 32'h0, 32'd42, 34);
        start = 1'b1;
        cancel = 1'b1;
        #1;
        check("cxl_done stall", stall, 1'b0);
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        check("cxl_done busy", busy, 1'b0);
        check("cxl_done done", done, 1'b0);

        // Back-to-back: start during DONE goes straight to PREP.
        issue(1'b0, 1'b0, 32'd1000, 32'd33);
        finish_op("b2b_first", 32'd10, 32'd30, 34);
        issue(1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        finish_op("b2b_second", 32'h0, 32'd6, 34);
        @(negedge clk);
        check("b2b done_pulse", done, 1'b0);

        // Asynchronous reset mid-CALC.
        issue(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst hi", hi, 32'h0);
        check("rst lo", lo, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("rst idle_after", seen_done, 1'b0);
        run_vec("post_rst", vecs[0]);

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            rv.m = 1'($urandom_range(0, 1));
            rv.s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       rv.a = 32'h0;
                1:       rv.a = 32'h8000_0000;
                default: rv.a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rv.b = 32'h0;
                1:       rv.b = 32'hFFFF_FFFF;
                2:       rv.b = 32'($urandom_range(1, 255));
                default: rv.b = $urandom;
            endcase
            model(rv.m, rv.s, rv.a, rv.b, rv.exp_hi, rv.exp_lo, rv.lat);
            run_vec($sformatf("rnd%0d m%0d s%0d %h %h", n, rv.m, rv.s, rv.a, rv.b), rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
